wb_port_sched: RTL and testbench

- Schedules the single register-file write port among three writeback sources: load return (memory), link write (call/jal PC+8 into $31) and ALU result.
- Drives the registered write strobe, address and data, plus the isLd/isCall selects used by the writeback select path.
- Keeps a per-register pending-load scoreboard so decode can stall on outstanding loads.
- Sits between execute/memory stages and the register file.

---
 rtl/wb_port_sched_pkg.sv | 33 +++
 rtl/wb_scoreboard.sv | 54 +++++
 rtl/wb_port_sched.sv | 186 ++++++++++++++++++
 tb/tb_wb_port_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_sched_pkg.sv
// wb_port_sched_pkg
//   Shared encodings for the writeback port scheduler: writeback source
//   select codes (bit 1 drives isLd, bit 0 drives isCall), the default link
//   register, the arbiter FSM state codes and the grant enumeration.
package wb_port_sched_pkg;

  // Writeback select codes: {isLd, isCall}
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_CALL = 2'b01;

  // Call/jal link writes land in $31 unless overridden
  localparam int LINK_REG_DEF = 31;

  // Arbiter FSM states
  localparam logic [1:0] ST_NORM       = 2'd0;
  localparam logic [1:0] ST_BOOST_CALL = 2'd1;
  localparam logic [1:0] ST_BOOST_ALU  = 2'd2;

  // Which source owns the write port this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_MEM  = 2'd1,
    GNT_CALL = 2'd2,
    GNT_ALU  = 2'd3
  } grant_e;

  // 4-bit wait counter increment that sticks at 15 instead of wrapping
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard
//   Pending-load bitmap, one bit per architectural register. A load issue
//   sets the bit of its destination, a load return clears it; when both hit
//   the same register in one cycle the set wins. Register 0 never pends.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     set_en, set_addr     load issued to memory and its destination
//     clr_en, clr_addr     load return written back and its destination
//     rs_addr, rt_addr     decode source operands
//     hazard               either source has an outstanding load
module wb_scoreboard #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          hazard
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign sb_d[gi] = 1'b0;
      end else begin : g_reg
        // Set has priority so a reissue racing the previous return stays pending
        assign sb_d[gi] = (set_en && set_addr == AW'(gi)) ? 1'b1 :
                          (clr_en && clr_addr == AW'(gi)) ? 1'b0 : sb_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // No bypass: a return in this cycle still reports the hazard until it lands
  assign hazard = sb_q[rs_addr] | sb_q[rt_addr];

endmodule

// File: rtl/wb_port_sched.sv
// wb_port_sched
//   Arbitrates the single register-file write port between load returns,
//   call link writes and ALU results (default priority mem > call > alu).
//   A starved call or ALU source is boosted to the top for one grant once it
//   has waited MAX_WAIT consecutive cycles. The grant is registered into the
//   write strobe/address/data and the isLd/isCall selects one cycle later.
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     mem_valid/rd/data, mem_ready       load return request and accept
//     call_valid/pc, call_ready          link write request and accept
//     alu_valid/rd/data, alu_ready       ALU result request and accept
//     ld_issue, ld_issue_rd              load issued to memory (scoreboard set)
//     rs_addr, rt_addr, hazard           decode operands and load-use stall
//     rf_we, rf_waddr, rf_wdata          registered register-file write
//     isLd, isCall                       registered writeback select
module wb_port_sched
  import wb_port_sched_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int MAX_WAIT = 4,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          call_valid,
  input  logic [DW-1:0] call_pc,
  output logic          call_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_issue_rd,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          hazard,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          isLd,
  output logic          isCall
);

  localparam logic [3:0]    WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [AW-1:0] LINK_ADDR  = AW'(LINK_REG);

  logic [1:0]    state_q, state_d;
  logic [3:0]    call_wait_q, call_wait_d;
  logic [3:0]    alu_wait_q, alu_wait_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    sel_q, sel_d;
  grant_e        gnt;

  // ---------------------------------------------------------------- arbiter
  // A boost only takes effect while the boosted source is asking; otherwise
  // the default priority applies for that cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (state_q == ST_BOOST_CALL && call_valid) begin
      gnt = GNT_CALL;
    end else if (state_q == ST_BOOST_ALU && alu_valid) begin
      gnt = GNT_ALU;
    end else if (mem_valid) begin
      gnt = GNT_MEM;
    end else if (call_valid) begin
      gnt = GNT_CALL;
    end else if (alu_valid) begin
      gnt = GNT_ALU;
    end
  end

  assign mem_ready  = (gnt == GNT_MEM);
  assign call_ready = (gnt == GNT_CALL);
  assign alu_ready  = (gnt == GNT_ALU);

  // ----------------------------------------------------------- wait counters
  assign call_wait_d = (call_valid && gnt != GNT_CALL) ? sat_inc4(call_wait_q) : 4'd0;
  assign alu_wait_d  = (alu_valid  && gnt != GNT_ALU)  ? sat_inc4(alu_wait_q)  : 4'd0;

  // --------------------------------------------------------------------- FSM
  // Boost is entered on the edge where the counter reaches the limit, so the
  // source is granted on the cycle after its MAX_WAIT-th blocked cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORM: begin
        if (call_wait_d >= WAIT_LIMIT) begin
          state_d = ST_BOOST_CALL;
        end else if (alu_wait_d >= WAIT_LIMIT) begin
          state_d = ST_BOOST_ALU;
        end
      end
      ST_BOOST_CALL: begin
        if (!call_valid || gnt == GNT_CALL) begin
          state_d = ST_NORM;
        end
      end
      ST_BOOST_ALU: begin
        if (!alu_valid || gnt == GNT_ALU) begin
          state_d = ST_NORM;
        end
      end
      default: state_d = ST_NORM;
    endcase
  end

  // ------------------------------------------------------------ write stage
  // Address, data and selects hold when idle; writes to $0 are accepted but
  // never strobed into the register file.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    case (gnt)
      GNT_MEM: begin
        we_d    = (mem_rd != '0);
        waddr_d = mem_rd;
        wdata_d = mem_data;
        sel_d   = SEL_MEM;
      end
      GNT_CALL: begin
        we_d    = (LINK_ADDR != '0);
        waddr_d = LINK_ADDR;
        wdata_d = call_pc;
        sel_d   = SEL_CALL;
      end
      GNT_ALU: begin
        we_d    = (alu_rd != '0);
        waddr_d = alu_rd;
        wdata_d = alu_data;
        sel_d   = SEL_ALU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_NORM;
      call_wait_q <= 4'd0;
      alu_wait_q  <= 4'd0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      sel_q       <= SEL_ALU;
    end else begin
      state_q     <= state_d;
      call_wait_q <= call_wait_d;
      alu_wait_q  <= alu_wait_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign isLd     = sel_q[1];
  assign isCall   = sel_q[0];

  // -------------------------------------------------------------- scoreboard
  wb_scoreboard #(
    .AW(AW)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (ld_issue),
    .set_addr(ld_issue_rd),
    .clr_en  (gnt == GNT_MEM),
    .clr_addr(mem_rd),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .hazard  (hazard)
  );

endmodule

// File: tb/tb_wb_port_sched.sv
module tb_wb_port_sched;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MAX_WAIT = 4;

  logic          clk, rst_n;
  logic          mem_valid, call_valid, alu_valid, ld_issue;
  logic [AW-1:0] mem_rd, alu_rd, ld_issue_rd, rs_addr, rt_addr;
  logic [DW-1:0] mem_data, call_pc, alu_data;
  logic          mem_ready, call_ready, alu_ready, hazard;
  logic          rf_we, isLd, isCall;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int n_vec = 0;
  int n_err = 0;

  wb_port_sched #(.DW(DW), .AW(AW), .MAX_WAIT(MAX_WAIT), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .call_valid(call_valid), .call_pc(call_pc), .call_ready(call_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .isLd(isLd), .isCall(isCall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (source-level view of the rules) -------
  // grant codes: 0 none, 1 mem, 2 call, 3 alu ; boost: 0 none, 1 call, 2 alu
  int          m_call_wait, m_alu_wait, m_boost;
  logic        m_we, m_isld, m_iscall;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_sb;

  task automatic model_reset();
    m_call_wait = 0; m_alu_wait = 0; m_boost = 0;
    m_we = 0; m_isld = 0; m_iscall = 0; m_waddr = 0; m_wdata = 0; m_sb = 0;
  endtask

  function automatic int model_grant();
    if (m_boost == 1 && call_valid) return 2;
    if (m_boost == 2 && alu_valid) return 3;
    if (mem_valid) return 1;
    if (call_valid) return 2;
    if (alu_valid) return 3;
    return 0;
  endfunction

  task automatic model_step(input int g);
    m_call_wait = (call_valid && g != 2) ? ((m_call_wait < 15) ? m_call_wait + 1 : 15) : 0;
    m_alu_wait  = (alu_valid && g != 3) ? ((m_alu_wait < 15) ? m_alu_wait + 1 : 15) : 0;
    if (m_boost == 1) begin
      if (!call_valid || g == 2) m_boost = 0;
    end else if (m_boost == 2) begin
      if (!alu_valid || g == 3) m_boost = 0;
    end else if (m_call_wait >= MAX_WAIT) m_boost = 1;
    else if (m_alu_wait >= MAX_WAIT) m_boost = 2;
    m_we = 0;
    if (g == 1) begin
      m_waddr = mem_rd; m_wdata = mem_data; m_isld = 1; m_iscall = 0; m_we = (mem_rd != 0);
      m_sb[mem_rd] = 1'b0;
    end else if (g == 2) begin
      m_waddr = 5'd31; m_wdata = call_pc; m_isld = 0; m_iscall = 1; m_we = 1;
    end else if (g == 3) begin
      m_waddr = alu_rd; m_wdata = alu_data; m_isld = 0; m_iscall = 0; m_we = (alu_rd != 0);
    end
    if (ld_issue) m_sb[ld_issue_rd] = 1'b1;
    m_sb[0] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 0; call_valid = 0; alu_valid = 0; ld_issue = 0;
    mem_rd = 0; alu_rd = 0; ld_issue_rd = 0; rs_addr = 0; rt_addr = 0;
    mem_data = 0; call_pc = 0; alu_data = 0;
  endtask

  // ------------------------------------------------------------- scenarios
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0b exp 0", rf_we); end
    n_vec++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d exp 0", rf_waddr); end
    n_vec++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %0h exp 0", rf_wdata); end
    n_vec++; if ({isLd, isCall} !== 2'b00) begin n_err++; $display("FAIL reset_sel: got %b exp 00", {isLd, isCall}); end
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %0b exp 0", hazard); end
    rst_n = 1;
    @(negedge clk);
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL release_we: got %0b exp 0", rf_we); end
    $display("test_reset done");
  endtask

  task automatic test_alu_basic();
    tick();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    @(negedge clk);
    n_vec++; if ({mem_ready, call_ready, alu_ready} !== 3'b001) begin n_err++; $display("FAIL alu_ready: got %b exp 001", {mem_ready, call_ready, alu_ready}); end
    tick();
    alu_valid = 0;
    @(negedge clk);
    n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %0b exp 1", rf_we); end
    n_vec++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL alu_waddr: got %0d exp 5", rf_waddr); end
    n_vec++; if (rf_wdata !== 32'h1234) begin n_err++; $display("FAIL alu_wdata: got %0h exp 1234", rf_wdata); end
    n_vec++; if ({isLd, isCall} !== 2'b00) begin n_err++; $display("FAIL alu_sel: got %b exp 00", {isLd, isCall}); end
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_idle_we: got %0b exp 0", rf_we); end
    n_vec++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL alu_hold_waddr: got %0d exp 5", rf_waddr); end
    $display("test_alu_basic done");
  endtask

  task automatic test_mem_alu();
    mem_valid = 1; mem_rd = 8; mem_data = 32'hAAAA_0008;
    alu_valid = 1; alu_rd = 9; alu_data = 32'hBBBB_0009;
    @(negedge clk);
    n_vec++; if ({mem_ready, call_ready, alu_ready} !== 3'b100) begin n_err++; $display("FAIL memalu_c0: got %b exp 100", {mem_ready, call_ready, alu_ready}); end
    tick();
    mem_valid = 0;
    @(negedge clk);
    n_vec++; if ({mem_ready, call_ready, alu_ready} !== 3'b001) begin n_err++; $display("FAIL memalu_c1: got %b exp 001", {mem_ready, call_ready, alu_ready}); end
    n_vec++; if ({rf_we, rf_waddr, rf_wdata, isLd, isCall} !== {1'b1, 5'd8, 32'hAAAA_0008, 2'b10}) begin
      n_err++; $display("FAIL memalu_w8: got we=%0b a=%0d d=%0h sel=%b exp we=1 a=8 d=aaaa0008 sel=10", rf_we, rf_waddr, rf_wdata, {isLd, isCall}); end
    tick();
    alu_valid = 0;
    @(negedge clk);
    n_vec++; if ({rf_we, rf_waddr, rf_wdata, isLd, isCall} !== {1'b1, 5'd9, 32'hBBBB_0009, 2'b00}) begin
      n_err++; $display("FAIL memalu_w9: got we=%0b a=%0d d=%0h sel=%b exp we=1 a=9 d=bbbb0009 sel=00", rf_we, rf_waddr, rf_wdata, {isLd, isCall}); end
    tick();
    $display("test_mem_alu done");
  endtask

  task automatic test_call_boost();
    mem_valid = 1; mem_rd = 10; mem_data = 32'h0000_C0DE;
    call_valid = 1; call_pc = 32'h0040_1008;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++; if (call_ready !== (i == 4)) begin n_err++; $display("FAIL boost_call_ready c%0d: got %0b exp %0b", i, call_ready, (i == 4)); end
      n_vec++; if (mem_ready !== (i != 4)) begin n_err++; $display("FAIL boost_mem_ready c%0d: got %0b exp %0b", i, mem_ready, (i != 4)); end
      if (i >= 1 && i <= 4) begin
        n_vec++; if ({rf_we, rf_waddr, isLd, isCall} !== {1'b1, 5'd10, 2'b10}) begin
          n_err++; $display("FAIL boost_memw c%0d: got we=%0b a=%0d sel=%b exp we=1 a=10 sel=10", i, rf_we, rf_waddr, {isLd, isCall}); end
      end
      if (i == 5) begin
        n_vec++; if ({rf_we, rf_waddr, rf_wdata, isLd, isCall} !== {1'b1, 5'd31, 32'h0040_1008, 2'b01}) begin
          n_err++; $display("FAIL boost_callw: got we=%0b a=%0d d=%0h sel=%b exp we=1 a=31 d=401008 sel=01", rf_we, rf_waddr, rf_wdata, {isLd, isCall}); end
      end
      tick();
      if (i == 4) call_valid = 0;
    end
    mem_valid = 0;
    tick();
    $display("test_call_boost done");
  endtask

  task automatic test_rd_zero();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    @(negedge clk);
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL rd0_ready: got %0b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    @(negedge clk);
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rd0_we: got %0b exp 0", rf_we); end
    tick();
    $display("test_rd_zero done");
  endtask

  task automatic test_hazard();
    ld_issue = 1; ld_issue_rd = 7; rs_addr = 7; rt_addr = 3;
    @(negedge clk);
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL hz_before: got %0b exp 0", hazard); end
    tick();
    ld_issue = 0;
    @(negedge clk);
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL hz_rs: got %0b exp 1", hazard); end
    tick();
    rs_addr = 0; rt_addr = 7;
    @(negedge clk);
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL hz_rt: got %0b exp 1", hazard); end
    tick();
    mem_valid = 1; mem_rd = 7; mem_data = 32'h77;
    @(negedge clk);
    n_vec++; if ({hazard, mem_ready} !== 2'b11) begin n_err++; $display("FAIL hz_nobypass: got %b exp 11", {hazard, mem_ready}); end
    tick();
    mem_valid = 0;
    @(negedge clk);
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL hz_cleared: got %0b exp 0", hazard); end
    tick();
    ld_issue = 1;
    tick();
    mem_valid = 1;
    @(negedge clk);
    n_vec++; if ({hazard, mem_ready} !== 2'b11) begin n_err++; $display("FAIL hz_race_pre: got %b exp 11", {hazard, mem_ready}); end
    tick();
    ld_issue = 0; mem_valid = 0;
    @(negedge clk);
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL hz_setwins: got %0b exp 1", hazard); end
    tick();
    mem_valid = 1;
    tick();
    mem_valid = 0;
    @(negedge clk);
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL hz_final: got %0b exp 0", hazard); end
    tick();
    $display("test_hazard done");
  endtask

  task automatic test_async_reset();
    ld_issue = 1; ld_issue_rd = 4; rs_addr = 4; rt_addr = 4;
    tick();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 12; alu_data = 32'hCAFE;
    @(negedge clk);
    n_vec++; if ({hazard, alu_ready} !== 2'b11) begin n_err++; $display("FAIL ar_pre: got %b exp 11", {hazard, alu_ready}); end
    rst_n = 0;
    #1;
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL ar_hazard: got %0b exp 0", hazard); end
    tick();
    alu_valid = 0;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
      n_err++; $display("FAIL ar_drop: got we=%0b a=%0d d=%0h exp we=0 a=0 d=0", rf_we, rf_waddr, rf_wdata); end
    rst_n = 1;
    @(negedge clk);
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL ar_release: got %0b exp 0", rf_we); end
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL ar_post: got %0b exp 0", rf_we); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int g;
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g = model_grant();
      n_vec++; if (mem_ready !== (g == 1)) begin n_err++; $display("FAIL rnd_mem_ready c%0d: got %0b exp %0b", c, mem_ready, (g == 1)); end
      n_vec++; if (call_ready !== (g == 2)) begin n_err++; $display("FAIL rnd_call_ready c%0d: got %0b exp %0b", c, call_ready, (g == 2)); end
      n_vec++; if (alu_ready !== (g == 3)) begin n_err++; $display("FAIL rnd_alu_ready c%0d: got %0b exp %0b", c, alu_ready, (g == 3)); end
      n_vec++; if (hazard !== (m_sb[rs_addr] | m_sb[rt_addr])) begin
        n_err++; $display("FAIL rnd_hazard c%0d: got %0b exp %0b", c, hazard, (m_sb[rs_addr] | m_sb[rt_addr])); end
      n_vec++; if (rf_we !== m_we) begin n_err++; $display("FAIL rnd_we c%0d: got %0b exp %0b", c, rf_we, m_we); end
      n_vec++; if (rf_waddr !== m_waddr) begin n_err++; $display("FAIL rnd_waddr c%0d: got %0d exp %0d", c, rf_waddr, m_waddr); end
      n_vec++; if (rf_wdata !== m_wdata) begin n_err++; $display("FAIL rnd_wdata c%0d: got %0h exp %0h", c, rf_wdata, m_wdata); end
      n_vec++; if ({isLd, isCall} !== {m_isld, m_iscall}) begin
        n_err++; $display("FAIL rnd_sel c%0d: got %b exp %b", c, {isLd, isCall}, {m_isld, m_iscall}); end
      @(posedge clk);
      model_step(g);
      #1;
      // sources keep their request stable until accepted
      if (!mem_valid || g == 1) begin
        mem_valid = ($urandom_range(0, 9) < 7); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      if (!call_valid || g == 2) begin
        call_valid = ($urandom_range(0, 9) < 4); call_pc = $urandom;
      end
      if (!alu_valid || g == 3) begin
        alu_valid = ($urandom_range(0, 9) < 5); alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_issue_rd = 5'($urandom_range(0, 7));
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = 5'($urandom_range(0, 7));
    end
    $display("test_random done");
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_alu_basic();
    test_mem_alu();
    test_call_boost();
    test_rd_zero();
    test_hazard();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
